// File: rtl/piso_serializer_if.sv
// piso_serializer_if: control, parallel-word and serial-output bundle for the serializer
interface piso_serializer_if #(parameter int N = 16);
  logic         start;
  logic         ena;
  logic [N-1:0] pin;
  logic         sout;
  logic         sval;
  logic         last;
  logic         busy;
  logic         done;
  modport master (output start, ena, pin, input sout, sval, last, busy, done);
  modport slave  (input start, ena, pin, output sout, sval, last, busy, done);
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: loads an N-bit word on start and emits it LSB first, one bit per enabled cycle
module piso_serializer #(parameter int N = 16) (
  input  logic clk,
  input  logic rst,
  piso_serializer_if.slave bus
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CMAX = CW'(N - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t        state, state_nx;
  logic [N-1:0]  sreg, sreg_nx;
  logic [CW-1:0] cnt, cnt_nx;
  // state, shift register and bit counter; reset clears everything without waiting for clk
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sreg  <= sreg_nx;
      cnt   <= cnt_nx;
    end
  // next-state logic and state-decoded outputs; a low ena freezes the frame where it stands
  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (bus.start) begin
        state_nx = SHIFT;
        sreg_nx  = bus.pin;
        cnt_nx   = '0;
      end
      SHIFT: if (bus.ena) begin
        sreg_nx  = {1'b0, sreg[N-1:1]};
        cnt_nx   = (cnt == CMAX) ? cnt : cnt + 1'b1;
        state_nx = (cnt == CMAX) ? DONE : SHIFT;
      end
      default: state_nx = IDLE;
    endcase
    bus.sout = (state == SHIFT) & sreg[0];
    bus.sval = (state == SHIFT) & bus.ena;
    bus.last = (state == SHIFT) & (cnt == CMAX);
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: table, hand-written corner sequences and randomized loopback against a bit-queue model
module tb_piso_serializer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  piso_serializer_if #(.N(16)) b16();
  piso_serializer_if #(.N(2))  b2();
  piso_serializer #(.N(16)) d16 (.clk(clk), .rst(rst), .bus(b16));
  piso_serializer #(.N(2))  d2  (.clk(clk), .rst(rst), .bus(b2));
  logic [4:0] o16, o2;
  assign o16 = {b16.sout, b16.sval, b16.last, b16.busy, b16.done};
  assign o2  = {b2.sout, b2.sval, b2.last, b2.busy, b2.done};
  int checks = 0;
  int passed = 0;
  typedef struct {
    logic        start;
    logic        ena;
    logic [15:0] pin;
    logic [4:0]  exp;
  } vec_t;
  vec_t tbl[19];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
  endtask

  function automatic vec_t mk(input logic s, input logic e, input logic [15:0] p, input logic [4:0] x);
    vec_t v;
    v.start = s; v.ena = e; v.pin = p; v.exp = x;
    return v;
  endfunction

  // one 16-bit frame: cycle 0 requests, then each cycle compares against the model
  // (in SHIFT sout is the next unsent bit of p, regardless of stalls)
  task automatic run16(input logic [15:0] p, input int pct, input int s0, input int s1, output int dc);
    int k;
    logic [15:0] rx;
    logic [4:0] exp;
    k = 0; rx = '0; dc = -1;
    @(posedge clk); #1;
    b16.start = 1'b1; b16.pin = p; b16.ena = 1'(($urandom % 2));
    @(negedge clk);
    check("idle16", 32'(o16), 32'd0);
    for (int c = 1; c < 200 && dc < 0; c++) begin
      @(posedge clk); #1;
      b16.start = (c == 3) ? 1'b1 : 1'($urandom % 2);
      b16.pin   = (c == 3) ? 16'hFFFF : 16'($urandom);
      b16.ena   = !(c >= s0 && c <= s1) && ($urandom_range(99) >= pct);
      @(negedge clk);
      exp = (k < 16) ? {p[k], b16.ena, (k == 15), 1'b1, 1'b0} : 5'b00011;
      check("frame16", 32'(o16), 32'(exp));
      if (k == 16) begin
        check("loopback16", 32'(rx), 32'(p));
        dc = c;
      end else begin
        if (b16.sval) rx = {b16.sout, rx[15:1]};
        if (b16.ena) k++;
      end
    end
    b16.start = 1'b0;
    check("frame16_done_seen", 32'(dc >= 0), 32'd1);
  endtask

  initial begin
    int dc;
    logic [4:0] exp2[5];
    tbl[0]  = mk(1, 1, 16'hA5C3, 5'b00000);
    tbl[1]  = mk(0, 1, 16'h0000, 5'b11010);
    tbl[2]  = mk(0, 1, 16'h1111, 5'b11010);
    tbl[3]  = mk(1, 1, 16'hFFFF, 5'b01010);
    tbl[4]  = mk(0, 1, 16'hFFFF, 5'b01010);
    tbl[5]  = mk(0, 1, 16'h0000, 5'b01010);
    tbl[6]  = mk(0, 1, 16'h0000, 5'b01010);
    tbl[7]  = mk(0, 1, 16'h0000, 5'b11010);
    tbl[8]  = mk(0, 1, 16'h0000, 5'b11010);
    tbl[9]  = mk(0, 1, 16'h0000, 5'b11010);
    tbl[10] = mk(0, 1, 16'h0000, 5'b01010);
    tbl[11] = mk(0, 1, 16'h0000, 5'b11010);
    tbl[12] = mk(0, 1, 16'h0000, 5'b01010);
    tbl[13] = mk(0, 1, 16'h0000, 5'b01010);
    tbl[14] = mk(0, 1, 16'h0000, 5'b11010);
    tbl[15] = mk(0, 1, 16'h0000, 5'b01010);
    tbl[16] = mk(0, 1, 16'h0000, 5'b11110);
    tbl[17] = mk(1, 1, 16'h0000, 5'b00011);
    tbl[18] = mk(0, 1, 16'h0000, 5'b00000);
    exp2 = '{5'b00000, 5'b01010, 5'b11110, 5'b00011, 5'b00000};
    b16.start = 0; b16.ena = 0; b16.pin = '0;
    b2.start = 0; b2.ena = 0; b2.pin = '0;
    #2;
    check("reset16", 32'(o16), 32'd0);
    check("reset2", 32'(o2), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 19; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      b16.start = tbl[i].start; b16.ena = tbl[i].ena; b16.pin = tbl[i].pin;
      @(negedge clk);
      check($sformatf("table_c%0d", i), 32'(o16), 32'(tbl[i].exp));
    end
    b16.start = 0;
    run16(16'hA5C3, 0, 5, 7, dc);
    check("stall_done_cycle", 32'(dc), 32'd20);
    run16(16'h5A3C, 0, 0, -1, dc);
    check("nostall_done_cycle", 32'(dc), 32'd17);
    @(posedge clk); #1;
    b16.start = 1; b16.pin = 16'h3C5A; b16.ena = 1;
    @(posedge clk); #1;
    b16.start = 0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("mid_frame_busy", 32'(b16.busy), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rst_async16", 32'(o16), 32'd0);
    check("rst_async2", 32'(o2), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_idle", 32'(o16), 32'd0);
    end
    run16(16'h1234, 0, 0, -1, dc);
    check("post_rst_done_cycle", 32'(dc), 32'd17);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      b2.start = (i == 0); b2.pin = (i == 0) ? 2'b10 : 2'($urandom); b2.ena = 1'b1;
      @(negedge clk);
      check($sformatf("n2_c%0d", i), 32'(o2), 32'(exp2[i]));
    end
    b2.start = 0;
    run16(16'h0000, 25, 0, -1, dc);
    run16(16'hFFFF, 25, 0, -1, dc);
    run16(16'h8001, 25, 0, -1, dc);
    for (int i = 0; i < 200; i++) run16(16'($urandom), int'($urandom_range(50)), 0, -1, dc);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the word width in bits; legal range N >= 2.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port start  input  1  request to load pin and begin a frame.
REQ-005 The block SHALL have port ena  input  1  shift enable; low stalls the frame in place.
REQ-006 The block SHALL have port pin  input  N  parallel word to transmit.
REQ-007 The block SHALL have port sout  output  1  current serial bit, LSB first.
REQ-008 The block SHALL have port sval  output  1  high when sout is consumed this cycle.
REQ-009 The block SHALL have port last  output  1  high while sout carries bit N-1.
REQ-010 The block SHALL have port busy  output  1  high while a frame is in progress.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse after the final bit.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, SHIFT and DONE, an N-bit shift register sreg, and a bit counter cnt of width max(1, clog2(N)).
REQ-013 In IDLE with start=1, the block SHALL load sreg<=pin, set cnt<=0, and go to SHIFT on the next edge; start=0 SHALL hold IDLE.
REQ-014 In SHIFT with ena=1, the block SHALL shift sreg right with 0 inserted at the MSB and increment cnt.
REQ-015 In SHIFT with ena=0, the block SHALL hold sreg, cnt and state unchanged, so sout stays stable.
REQ-016 In SHIFT with ena=1 and cnt==N-1, the block SHALL go to DONE instead of incrementing cnt.
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-018 sout SHALL equal sreg[0] in SHIFT and 0 in all other states.
REQ-019 sval SHALL equal (state==SHIFT) AND ena.
REQ-020 last SHALL equal (state==SHIFT) AND (cnt==N-1).
REQ-021 busy SHALL be high in SHIFT and DONE, and low in IDLE.
REQ-022 done SHALL be high only in DONE.
REQ-023 start SHALL be ignored in SHIFT and DONE; the earliest new frame is accepted in IDLE.
REQ-024 Changes on pin after the load cycle SHALL NOT affect the frame in progress.
REQ-025 Latency with ena held high: start sampled at edge 0; bit k on sout during cycle k+1 (k=0..N-1); done in cycle N+1; next start accepted in cycle N+2.
REQ-026 Stall cycles (ena=0) SHALL extend the frame one cycle each, with no bit lost or duplicated.
REQ-027 Output bit order SHALL be LSB first, so a right-shift, MSB-insert N-bit receive register clocked by sval reassembles pin exactly after N accepted bits.

Reset
REQ-028 rst=0 SHALL immediately, without waiting for clk, force state=IDLE, sreg=0, cnt=0, sout=0, sval=0, last=0, busy=0, done=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no done pulse; after release the block SHALL wait in IDLE for a new start.
REQ-030 The first start SHALL be accepted on the first rising clk edge after rst deasserts.

Verification
REQ-031 Basic frame: N=16, pin=16'hA5C3, ena=1, start for one cycle -> sout over cycles 1..16 = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; last high only in cycle 16; done high only in cycle 17; busy high in cycles 1..17.
REQ-032 Stall: same as REQ-031 with ena=0 during cycles 5..7 -> sout holds bit 4 (value 0) through the stall; sval=0 during the stall; done moves to cycle 20; bit sequence unchanged.
REQ-033 Start and pin ignored while busy: start=1 and pin=16'hFFFF in cycle 3 -> frame still emits the 16'hA5C3 sequence; no restart.
REQ-034 Async reset mid-frame: rst=0 between edges in cycle 9 -> all outputs 0 immediately; no done pulse; next start after release sends the new pin correctly.
REQ-035 Loopback: sout fed into a right-shift receive register enabled by sval, with pins 16'h0000, 16'hFFFF, 16'h8001 and 200 random values, including random ena stalls -> the received word equals pin in each cycle where done=1.
REQ-036 Boundary width: N=2, pin=2'b10 -> sout=0 then 1; last high on the second bit; done in cycle 3.
